// File: rtl/tone_source.sv
// Square-wave tone source for the codec write stage: note code in, 24-bit stereo samples out on a valid/ready stream.
// Define ENVELOPE_EN to add the linear attack/release envelope; without it the output is exactly +/-AMPLITUDE or 0.
module tone_source #(
  parameter logic [23:0] AMPLITUDE = 24'h200000,
  parameter logic [7:0]  ENV_STEP  = 8'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  note,
  input  logic        sample_ready,
  output logic        sample_valid,
  output logic [23:0] sample_left,
  output logic [23:0] sample_right,
  output logic        active
);

  // Half-period in 48 kHz samples for C4..B4.
  function automatic logic [6:0] half_period(input logic [3:0] code);
    case (code)
      4'd1:    half_period = 7'd92;
      4'd2:    half_period = 7'd87;
      4'd3:    half_period = 7'd82;
      4'd4:    half_period = 7'd77;
      4'd5:    half_period = 7'd73;
      4'd6:    half_period = 7'd69;
      4'd7:    half_period = 7'd65;
      4'd8:    half_period = 7'd61;
      4'd9:    half_period = 7'd58;
      4'd10:   half_period = 7'd55;
      4'd11:   half_period = 7'd51;
      4'd12:   half_period = 7'd49;
      default: half_period = 7'd1;
    endcase
  endfunction

  logic        valid_reg;
  logic [3:0]  note_q_reg, note_q_next;
  logic [6:0]  cnt_reg, cnt_next;
  logic        pol_reg, pol_next;
  logic [23:0] sample_reg, sample_next;
  logic        active_reg, active_next;
  logic [3:0]  n;
  logic        transfer;
  logic [23:0] level;

  assign transfer = valid_reg & sample_ready;

  always_comb begin
    n           = (note > 4'd12) ? 4'd0 : note;
    note_q_next = note_q_reg;
    cnt_next    = cnt_reg;
    pol_next    = pol_reg;
    if (n != 4'd0 && n != note_q_reg) begin
      note_q_next = n;
      cnt_next    = 7'd0;
      pol_next    = 1'b0;
    end else if (note_q_reg != 4'd0 && cnt_reg == half_period(note_q_reg) - 7'd1) begin
      cnt_next = 7'd0;
      pol_next = ~pol_reg;
    end else if (note_q_reg != 4'd0) begin
      cnt_next = cnt_reg + 7'd1;
    end
  end

  assign level = pol_next ? (~AMPLITUDE + 24'd1) : AMPLITUDE;

`ifdef ENVELOPE_EN
  logic [7:0]         env_reg, env_next;
  logic [8:0]         env_sum;
  logic signed [31:0] product;

  always_comb begin
    env_sum = {1'b0, env_reg} + {1'b0, ENV_STEP};
    if (n != 4'd0)
      env_next = env_sum[8] ? 8'hFF : env_sum[7:0];
    else
      env_next = (env_reg > ENV_STEP) ? env_reg - ENV_STEP : 8'd0;
    // Bits [31:8] of the 32-bit product are the arithmetic >>>8 truncated to 24 bits.
    product     = $signed({{8{level[23]}}, level}) * $signed({24'd0, env_next});
    sample_next = (note_q_next == 4'd0) ? 24'd0 : product[31:8];
    active_next = (env_next != 8'd0);
  end

  always_ff @(posedge clock) begin
    if (!reset)
      env_reg <= 8'd0;
    else if (transfer)
      env_reg <= env_next;
  end
`else
  always_comb begin
    sample_next = (n != 4'd0) ? level : 24'd0;
    active_next = (n != 4'd0);
  end
`endif

  // valid rises on the first cycle out of reset; a held sample is dropped by reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_reg  <= 1'b0;
      note_q_reg <= 4'd0;
      cnt_reg    <= 7'd0;
      pol_reg    <= 1'b0;
      sample_reg <= 24'd0;
      active_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b1;
      if (transfer) begin
        note_q_reg <= note_q_next;
        cnt_reg    <= cnt_next;
        pol_reg    <= pol_next;
        sample_reg <= sample_next;
        active_reg <= active_next;
      end
    end
  end

  assign sample_valid = valid_reg;
  assign sample_left  = sample_reg;
  assign sample_right = sample_reg;
  assign active       = active_reg;

endmodule

// File: tb/tb_tone_source.sv
// Scoreboard bench for tone_source: driver pushes the expected output per cycle from a phase-position model, monitor pops and compares.
// Honours ENVELOPE_EN the same way the design does.
module tb_tone_source;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  note = 4'd0;
  logic        sample_ready = 1'b1;
  logic        sample_valid;
  logic [23:0] sample_left;
  logic [23:0] sample_right;
  logic        active;

  tone_source dut (
    .clock        (clock),
    .reset        (reset),
    .note         (note),
    .sample_ready (sample_ready),
    .sample_valid (sample_valid),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .active       (active)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [23:0] sample;
    logic        active;
    logic        xfer;
    int          note;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;
  bit   started = 0;

  // Model state: the sounding note and how many samples into it we are.
  int half_tab[13] = '{0, 92, 87, 82, 77, 73, 69, 65, 61, 58, 55, 51, 49};
  bit m_valid = 0;
  int m_note = 0;
  int m_pos = 0;
  int m_env = 0;
  int m_sample = 0;
  bit m_active = 0;

  task automatic model_edge();
    exp_t e;
    int n, level;
    bit xfer;
    xfer = 0;
    n = (note > 12) ? 0 : int'(note);
    if (!reset) begin
      m_valid = 0; m_note = 0; m_pos = 0; m_env = 0; m_sample = 0; m_active = 0;
    end else if (m_valid && sample_ready) begin
      xfer = 1;
      if (n != 0 && n != m_note) begin
        m_note = n;
        m_pos = 0;
      end else if (m_note != 0) begin
        m_pos++;
      end
      level = ((m_pos / half_tab[m_note]) % 2 == 0) ? 'h200000 : -'h200000;
`ifdef ENVELOPE_EN
      m_env = (n != 0) ? ((m_env + 4 > 255) ? 255 : m_env + 4)
                       : ((m_env - 4 < 0) ? 0 : m_env - 4);
      m_sample = (m_note == 0) ? 0 : (level * m_env) >>> 8;
      m_active = (m_env != 0);
`else
      m_sample = (n != 0) ? level : 0;
      m_active = (n != 0);
`endif
    end else begin
      m_valid = 1;
    end
    e.valid = m_valid;
    e.sample = m_sample[23:0];
    e.active = m_active;
    e.xfer = xfer;
    e.note = n;
    sb_q.push_back(e);
    started = 1;
  endtask

  task automatic drive(input logic rst, input logic [3:0] nt, input logic rdy, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      reset = rst;
      note = nt;
      sample_ready = rdy;
      @(posedge clock);
      model_edge();
    end
  endtask

  // Monitor: one popped expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (started) begin
        checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL scoreboard_underflow: no expectation queued at t=%0t", $time);
        end else begin
          e = sb_q.pop_front();
          if (sample_valid !== e.valid || sample_left !== e.sample ||
              sample_right !== e.sample || active !== e.active) begin
            $display("FAIL output t=%0t: got valid=%b L=%06h R=%06h active=%b, required valid=%b L=R=%06h active=%b",
                     $time, sample_valid, sample_left, sample_right, active, e.valid, e.sample, e.active);
          end else begin
            passed++;
            if (e.xfer)
              $display("xfer t=%0t note=%0d sample=%06h active=%b", $time, e.note, sample_left, active);
          end
        end
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    logic [3:0] rn;
    drive(1'b0, 4'd0, 1'b1, 3);     // reset
    drive(1'b1, 4'd0, 1'b1, 20);    // silence
    drive(1'b1, 4'd10, 1'b1, 250);  // A: 55/55 square
    drive(1'b1, 4'd10, 1'b0, 30);   // stall mid-tone
    drive(1'b1, 4'd10, 1'b1, 100);
    drive(1'b1, 4'd1, 1'b1, 50);
    drive(1'b1, 4'd12, 1'b1, 120);  // switch to B
    drive(1'b1, 4'd0, 1'b1, 80);    // release tail
    for (int seg = 0; seg < 10; seg++) begin
      len = $urandom_range(5, 90);
      rn = 4'($urandom_range(0, 15));
      for (int c = 0; c < len; c++)
        drive(1'b1, rn, ($urandom_range(0, 4) != 0), 1);
    end
    drive(1'b1, 4'd5, 1'b1, 20);
    drive(1'b0, 4'd5, 1'b1, 2);     // reset mid-tone
    drive(1'b1, 4'd5, 1'b1, 15);
    @(negedge clock);
    #1;
    checks++;
    if (sb_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d leftover, required 0", sb_q.size());
    else
      passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
